// File: rtl/fir_pkg.sv
// fir_pkg
// Shared definitions for the FIR post-processing stages.
//   - default fixed-point formats and their total widths
//   - acc_t: accumulator type for the default format and decimation
//   - sat_q: clamp a wide signed value into a narrower two's-complement range
package fir_pkg;

  localparam int IN_INTE_WL_DEF  = 4;
  localparam int IN_FRAC_WL_DEF  = 12;
  localparam int OUT_INTE_WL_DEF = 4;
  localparam int OUT_FRAC_WL_DEF = 12;
  localparam int DECIM_DEF       = 4;

  localparam int IN_W_DEF  = IN_INTE_WL_DEF + IN_FRAC_WL_DEF;
  localparam int OUT_W_DEF = OUT_INTE_WL_DEF + OUT_FRAC_WL_DEF;
  localparam int ACC_W_DEF = IN_W_DEF + $clog2(DECIM_DEF);

  // Working width for the requantizer; wide enough for any sane format here.
  localparam int SAT_W = 64;

  typedef logic signed [ACC_W_DEF-1:0] acc_t;

  // Clamp x into the signed range of an out_w-bit word. The result keeps
  // SAT_W bits; the caller takes the low out_w bits.
  function automatic logic signed [SAT_W-1:0] sat_q(input logic signed [SAT_W-1:0] x,
                                                     input int out_w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) << (out_w - 1)) - SAT_W'(1);
    lo = -hi - SAT_W'(1);
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// fir_out_fifo
// First-word-fall-through FIFO with full/empty/level. Pointers carry an
// extra wrap bit so full and empty are distinguishable. A push while full is
// accepted only when a pop happens on the same edge.
// Ports:
//   clk, rst      clock, async active-high reset
//   push_i        write request, wdata_i written if accepted
//   pop_i         read request, ignored when empty
//   rdata_o       head word (0 when empty)
//   full_o        no free entry
//   empty_o       no stored entry
//   level_o       current occupancy
module fir_out_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign level_o = wr_q - rd_q;

  // Storage is not reset; the head is masked to zero while empty instead.
  assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/fir_decim_avg.sv
// fir_decim_avg
// Averages every DECIM accepted FIR samples, requantizes the mean to the
// output format with saturation and queues it in an output FIFO.
// Build option: DECIM_ROUND_EN selects round-half-up (instead of floor) for
// both the mean shift and the fractional truncation.
// Ports:
//   clk, rst      clock, async active-high reset
//   data_in       FIR sample, in_valid qualifies it (gaps allowed)
//   data_out      FIFO head, out_valid when non-empty, out_ready pops
//   overflow      sticky: a result was dropped on a full FIFO
//   fifo_level    FIFO occupancy
module fir_decim_avg
  import fir_pkg::*;
#(
  parameter int IN_INTE_WL  = 4,
  parameter int IN_FRAC_WL  = 12,
  parameter int OUT_INTE_WL = 4,
  parameter int OUT_FRAC_WL = 12,
  parameter int DECIM       = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic signed [IN_INTE_WL-1:-IN_FRAC_WL]  data_in,
  input  logic                                    in_valid,
  output logic signed [OUT_INTE_WL-1:-OUT_FRAC_WL] data_out,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic                                    overflow,
  output logic [$clog2(FIFO_DEPTH):0]             fifo_level
);

  localparam int IN_W  = IN_INTE_WL + IN_FRAC_WL;
  localparam int OUT_W = OUT_INTE_WL + OUT_FRAC_WL;
  localparam int L     = $clog2(DECIM);
  localparam int ACC_W = IN_W + L;
  localparam int DROP  = (OUT_FRAC_WL < IN_FRAC_WL) ? IN_FRAC_WL - OUT_FRAC_WL : 0;
  localparam int PAD   = (OUT_FRAC_WL > IN_FRAC_WL) ? OUT_FRAC_WL - IN_FRAC_WL : 0;
  localparam int DROP_M1 = (DROP > 0) ? DROP - 1 : 0;

`ifdef DECIM_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  // Half an LSB of whatever each shift discards; zero in floor mode.
  localparam logic signed [SAT_W-1:0] RND_MEAN = ROUND ? SAT_W'(SAT_W'(1) << (L - 1)) : '0;
  localparam logic signed [SAT_W-1:0] RND_FRAC =
    (ROUND && DROP > 0) ? SAT_W'(SAT_W'(1) << DROP_M1) : '0;

  logic signed [IN_W-1:0]  din;
  logic signed [ACC_W-1:0] acc_q, acc_d, sum;
  logic [L-1:0]            phase_q, phase_d;
  logic                    overflow_q, overflow_d;
  logic                    dump, pop, fifo_full, fifo_empty;
  logic signed [SAT_W-1:0] sum_w, mean_w, q_w, sat_w;
  logic [OUT_W-1:0]        result, head;

  assign din  = data_in;
  assign sum  = acc_q + {{L{din[IN_W-1]}}, din};
  assign dump = in_valid && (phase_q == L'(DECIM - 1));
  assign pop  = out_valid && out_ready;

  always_comb begin
    sum_w  = {{(SAT_W-ACC_W){sum[ACC_W-1]}}, sum};
    mean_w = (sum_w + RND_MEAN) >>> L;
    q_w    = ((mean_w + RND_FRAC) >>> DROP) <<< PAD;
    sat_w  = sat_q(q_w, OUT_W);
    result = sat_w[OUT_W-1:0];
  end

  always_comb begin
    acc_d      = acc_q;
    phase_d    = phase_q;
    overflow_d = overflow_q;
    if (in_valid) begin
      if (dump) begin
        acc_d   = '0;
        phase_d = '0;
        // A full FIFO only takes the word if the head leaves on this edge.
        if (fifo_full && !pop) overflow_d = 1'b1;
      end else begin
        acc_d   = sum;
        phase_d = phase_q + L'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      phase_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
    end
  end

  fir_out_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (dump),
    .pop_i   (pop),
    .wdata_i (result),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign data_out  = head;
  assign out_valid = !fifo_empty;
  assign overflow  = overflow_q;

endmodule
